tcb_dec: RTL and testbench



---
 rtl/tcb_dec.sv | 126 ++++++++++++
 tb/tb_tcb_dec.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcb_dec.sv
// rtl/tcb_dec.sv - TCB address decoder: one manager stream fanned out to PN subordinates by address range
module tcb_dec #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned BW  = DW/8,
  parameter int unsigned PN  = 2,
  parameter int unsigned DLY = 1,
  parameter logic [AW-1:0] AS [0:PN-1] = '{32'h0000_0000, 32'h8000_0000},
  parameter logic [AW-1:0] AM [0:PN-1] = '{32'h8000_0000, 32'h8000_0000}
) (
  input  logic                   clk,
  input  logic                   rst,
  // upstream (subordinate side of this block)
  input  logic                   s_vld,
  input  logic                   s_wen,
  input  logic [AW-1:0]          s_adr,
  input  logic [BW-1:0]          s_ben,
  input  logic [DW-1:0]          s_wdt,
  output logic                   s_rdy,
  output logic [DW-1:0]          s_rdt,
  output logic                   s_err,
  // downstream (manager side of this block)
  output logic [PN-1:0]          m_vld,
  output logic [PN-1:0]          m_wen,
  output logic [PN-1:0][AW-1:0]  m_adr,
  output logic [PN-1:0][BW-1:0]  m_ben,
  output logic [PN-1:0][DW-1:0]  m_wdt,
  input  logic [PN-1:0]          m_rdy,
  input  logic [PN-1:0][DW-1:0]  m_rdt,
  input  logic [PN-1:0]          m_err
);

  localparam int unsigned SW = (PN > 1) ? $clog2(PN) : 1;

  logic [PN-1:0] hit;
  logic          hit_any;
  logic [SW-1:0] sel;
  logic          trn;

  // select pipeline: stage 0 captures the transfer, the last stage drives the response mux
  logic [DLY-1:0]         val_q, val_d;
  logic [DLY-1:0]         hit_q, hit_d;
  logic [DLY-1:0][SW-1:0] sel_q, sel_d;

  logic          val_l;
  logic          hit_l;
  logic [SW-1:0] sel_l;

  // address decode; scanning downward leaves the lowest matching index in sel
  always_comb begin
    hit = '0;
    sel = '0;
    for (int i = PN - 1; i >= 0; i--) begin
      hit[i] = ((s_adr & AM[i]) == AS[i]);
      if (hit[i]) begin
        sel = SW'(i);
      end
    end
    hit_any = |hit;
  end

  // request fan-out: only the selected port sees vld, payload is broadcast
  always_comb begin
    m_vld = '0;
    m_wen = '0;
    m_adr = '0;
    m_ben = '0;
    m_wdt = '0;
    for (int i = 0; i < PN; i++) begin
      m_vld[i] = s_vld & hit_any & (sel == SW'(i));
      m_wen[i] = s_wen;
      m_adr[i] = s_adr;
      m_ben[i] = s_ben;
      m_wdt[i] = s_wdt;
    end
    // unmapped requests are accepted at once and answered with an error
    s_rdy = hit_any ? m_rdy[sel] : 1'b1;
    trn   = s_vld & s_rdy;
  end

  // next state of the select pipeline
  always_comb begin
    val_d    = val_q;
    hit_d    = hit_q;
    sel_d    = sel_q;
    val_d[0] = trn;
    hit_d[0] = hit_any;
    sel_d[0] = sel;
    for (int i = 1; i < DLY; i++) begin
      val_d[i] = val_q[i-1];
      hit_d[i] = hit_q[i-1];
      sel_d[i] = sel_q[i-1];
    end
  end

  // pipeline registers; reset discards every in-flight response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q <= '0;
      hit_q <= '0;
      sel_q <= '0;
    end else begin
      val_q <= val_d;
      hit_q <= hit_d;
      sel_q <= sel_d;
    end
  end

  // response mux from the last stage; idle cycles drive zeros rather than X
  always_comb begin
    val_l = val_q[DLY-1];
    hit_l = hit_q[DLY-1];
    sel_l = sel_q[DLY-1];
    s_rdt = '0;
    s_err = 1'b0;
    if (val_l) begin
      if (hit_l) begin
        s_rdt = m_rdt[sel_l];
        s_err = m_err[sel_l];
      end else begin
        s_err = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tcb_dec.sv
// tb/tb_tcb_dec.sv - directed self-checking bench for tcb_dec
module tb_tcb_dec;

  logic clk;
  logic rst;

  logic        s_vld;
  logic        s_wen;
  logic [31:0] s_adr;
  logic [3:0]  s_ben;
  logic [31:0] s_wdt;
  logic [1:0]        m_rdy;
  logic [1:0][31:0]  m_rdt;
  logic [1:0]        m_err;

  logic             a_s_rdy, b_s_rdy, c_s_rdy;
  logic [31:0]      a_s_rdt, b_s_rdt, c_s_rdt;
  logic             a_s_err, b_s_err, c_s_err;
  logic [1:0]       a_m_vld, b_m_vld, c_m_vld;
  logic [1:0]       a_m_wen, b_m_wen, c_m_wen;
  logic [1:0][31:0] a_m_adr, b_m_adr, c_m_adr;
  logic [1:0][3:0]  a_m_ben, b_m_ben, c_m_ben;
  logic [1:0][31:0] a_m_wdt, b_m_wdt, c_m_wdt;

  int n_vec;
  int n_bad;

  // A: default map, DLY=1
  tcb_dec #(.DLY(1)) u_a (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
    .s_rdy(a_s_rdy), .s_rdt(a_s_rdt), .s_err(a_s_err),
    .m_vld(a_m_vld), .m_wen(a_m_wen), .m_adr(a_m_adr), .m_ben(a_m_ben), .m_wdt(a_m_wdt),
    .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err)
  );

  // B: sparse map with holes, DLY=3
  tcb_dec #(
    .DLY(3),
    .AS('{32'h0000_0000, 32'h1000_0000}),
    .AM('{32'hF000_0000, 32'hF000_0000})
  ) u_b (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
    .s_rdy(b_s_rdy), .s_rdt(b_s_rdt), .s_err(b_s_err),
    .m_vld(b_m_vld), .m_wen(b_m_wen), .m_adr(b_m_adr), .m_ben(b_m_ben), .m_wdt(b_m_wdt),
    .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err)
  );

  // C: fully overlapping regions, DLY=2
  tcb_dec #(
    .DLY(2),
    .AS('{32'h0000_0000, 32'h0000_0000}),
    .AM('{32'h0000_0000, 32'h0000_0000})
  ) u_c (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
    .s_rdy(c_s_rdy), .s_rdt(c_s_rdt), .s_err(c_s_err),
    .m_vld(c_m_vld), .m_wen(c_m_wen), .m_adr(c_m_adr), .m_ben(c_m_ben), .m_wdt(c_m_wdt),
    .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_vld = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    s_vld = 1'b0;
    s_wen = 1'b0;
    s_adr = '0;
    s_ben = 4'hF;
    s_wdt = '0;
    m_rdy = 2'b11;
    m_rdt[0] = 32'h1111_1111;
    m_rdt[1] = 32'h2222_2222;
    m_err = 2'b00;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({a_s_err, b_s_err, c_s_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_err: got %b want 000", {a_s_err, b_s_err, c_s_err});
    end
    n_vec++;
    if ({a_s_rdt, b_s_rdt, c_s_rdt} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_rdt: got %h want 0", {a_s_rdt, b_s_rdt, c_s_rdt});
    end
    n_vec++;
    if ({a_m_vld, b_m_vld, c_m_vld} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_vld: got %b want 000000", {a_m_vld, b_m_vld, c_m_vld});
    end
    step();
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_broadcast();
    logic [81:0] exp;
    step();
    s_vld = 1'b0;
    s_wen = 1'b1;
    s_adr = 32'h1234_5678;
    s_ben = 4'hA;
    s_wdt = 32'hDEAD_BEEF;
    exp = {2'b11, 8'hAA, 64'hDEAD_BEEF_DEAD_BEEF, 8'h0};
    exp[81:64] = {2'b11, 8'hAA, 8'h0};
    @(negedge clk);
    n_vec++;
    if ({a_m_wen, a_m_ben, a_m_wdt, a_m_adr} !== {2'b11, 8'hAA, 64'hDEAD_BEEF_DEAD_BEEF, 64'h1234_5678_1234_5678}) begin
      n_bad++;
      $display("FAIL bcast_a: got %h", {a_m_wen, a_m_ben, a_m_wdt, a_m_adr});
    end
    n_vec++;
    if ({b_m_wen, b_m_ben, b_m_wdt, b_m_adr} !== {2'b11, 8'hAA, 64'hDEAD_BEEF_DEAD_BEEF, 64'h1234_5678_1234_5678}) begin
      n_bad++;
      $display("FAIL bcast_b: got %h", {b_m_wen, b_m_ben, b_m_wdt, b_m_adr});
    end
    n_vec++;
    if ({c_m_wen, c_m_ben, c_m_wdt, c_m_adr} !== {2'b11, 8'hAA, 64'hDEAD_BEEF_DEAD_BEEF, 64'h1234_5678_1234_5678}) begin
      n_bad++;
      $display("FAIL bcast_c: got %h", {c_m_wen, c_m_ben, c_m_wdt, c_m_adr});
    end
    n_vec++;
    if ({a_m_vld, b_m_vld, c_m_vld} !== 6'b0) begin
      n_bad++;
      $display("FAIL bcast_vld: got %b want 000000 (exp tag %h)", {a_m_vld, b_m_vld, c_m_vld}, exp[81:80]);
    end
    s_wen = 1'b0;
    s_ben = 4'hF;
    s_wdt = '0;
    idle(4);
  endtask

  task automatic test_basic();
    step();
    s_vld = 1'b1;
    s_adr = 32'h0000_0010;
    @(negedge clk);
    n_vec++;
    if (a_m_vld !== 2'b01) begin n_bad++; $display("FAIL basic_vld0: got %b want 01", a_m_vld); end
    n_vec++;
    if (a_s_rdy !== 1'b1) begin n_bad++; $display("FAIL basic_rdy: got %b want 1", a_s_rdy); end
    n_vec++;
    if ({a_s_err, a_s_rdt} !== 33'h0) begin n_bad++; $display("FAIL basic_idle: got %h want 0", {a_s_err, a_s_rdt}); end
    step();
    s_adr = 32'h8000_0020;
    @(negedge clk);
    n_vec++;
    if (a_m_vld !== 2'b10) begin n_bad++; $display("FAIL basic_vld1: got %b want 10", a_m_vld); end
    n_vec++;
    if ({a_s_err, a_s_rdt} !== {1'b0, 32'h1111_1111}) begin n_bad++; $display("FAIL basic_rsp0: got %h want 011111111", {a_s_err, a_s_rdt}); end
    step();
    s_vld = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({a_s_err, a_s_rdt} !== {1'b0, 32'h2222_2222}) begin n_bad++; $display("FAIL basic_rsp1: got %h want 022222222", {a_s_err, a_s_rdt}); end
    step();
    @(negedge clk);
    n_vec++;
    if ({a_s_err, a_s_rdt} !== 33'h0) begin n_bad++; $display("FAIL basic_after: got %h want 0", {a_s_err, a_s_rdt}); end
    idle(4);
  endtask

  task automatic test_backpressure();
    step();
    m_rdy = 2'b01;
    s_vld = 1'b1;
    s_adr = 32'h8000_0004;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if ({a_s_rdy, a_m_vld} !== 3'b010) begin n_bad++; $display("FAIL bp_stall%0d: rdy/vld got %b want 010", k, {a_s_rdy, a_m_vld}); end
      n_vec++;
      if ({a_s_err, a_s_rdt} !== 33'h0) begin n_bad++; $display("FAIL bp_norsp%0d: got %h want 0", k, {a_s_err, a_s_rdt}); end
      step();
    end
    m_rdy = 2'b11;
    @(negedge clk);
    n_vec++;
    if ({a_s_rdy, a_m_vld} !== 3'b110) begin n_bad++; $display("FAIL bp_accept: rdy/vld got %b want 110", {a_s_rdy, a_m_vld}); end
    n_vec++;
    if ({a_s_err, a_s_rdt} !== 33'h0) begin n_bad++; $display("FAIL bp_early: got %h want 0", {a_s_err, a_s_rdt}); end
    step();
    s_vld = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({a_s_err, a_s_rdt} !== {1'b0, 32'h2222_2222}) begin n_bad++; $display("FAIL bp_rsp: got %h want 022222222", {a_s_err, a_s_rdt}); end
    step();
    @(negedge clk);
    n_vec++;
    if ({a_s_err, a_s_rdt} !== 33'h0) begin n_bad++; $display("FAIL bp_single: got %h want 0", {a_s_err, a_s_rdt}); end
    idle(4);
  endtask

  task automatic test_err_passthrough();
    step();
    m_err = 2'b10;
    s_vld = 1'b1;
    s_adr = 32'h8000_0008;
    step();
    s_vld = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({a_s_err, a_s_rdt} !== {1'b1, 32'h2222_2222}) begin n_bad++; $display("FAIL errpass: got %h want 122222222", {a_s_err, a_s_rdt}); end
    step();
    m_err = 2'b00;
    @(negedge clk);
    n_vec++;
    if (a_s_err !== 1'b0) begin n_bad++; $display("FAIL errpass_clr: got %b want 0", a_s_err); end
    idle(4);
  endtask

  task automatic test_unmapped();
    step();
    m_rdy = 2'b00;
    s_vld = 1'b1;
    s_adr = 32'h2000_0000;
    @(negedge clk);
    n_vec++;
    if ({b_s_rdy, b_m_vld} !== 3'b100) begin n_bad++; $display("FAIL unmap_req: rdy/vld got %b want 100", {b_s_rdy, b_m_vld}); end
    for (int k = 1; k <= 3; k++) begin
      step();
      s_vld = 1'b0;
      m_rdy = 2'b11;
      @(negedge clk);
      n_vec++;
      if ({b_s_err, b_s_rdt} !== {(k == 3), 32'h0}) begin
        n_bad++;
        $display("FAIL unmap_rsp%0d: got %h want %h", k, {b_s_err, b_s_rdt}, {(k == 3), 32'h0});
      end
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] adr_t [8];
    logic [31:0] rdt_t [8];
    logic        err_t [8];
    logic [31:0] er;
    logic        ee;
    adr_t = '{32'h0000_0100, 32'h1000_0200, 32'h0000_0300, 32'h3000_0000,
              32'h1000_0400, 32'h0000_0500, 32'h1000_0600, 32'h0000_0700};
    rdt_t = '{32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000,
              32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 32'h1111_1111};
    err_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int t = 0; t < 11; t++) begin
      step();
      if (t < 8) begin
        s_vld = 1'b1;
        s_adr = adr_t[t];
      end else begin
        s_vld = 1'b0;
      end
      @(negedge clk);
      if (t < 8) begin
        n_vec++;
        if (b_s_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy%0d: got %b want 1", t, b_s_rdy); end
      end
      er = 32'h0;
      ee = 1'b0;
      if (t >= 3) begin
        er = rdt_t[t-3];
        ee = err_t[t-3];
      end
      n_vec++;
      if ({b_s_err, b_s_rdt} !== {ee, er}) begin
        n_bad++;
        $display("FAIL b2b_rsp%0d: got %h want %h", t, {b_s_err, b_s_rdt}, {ee, er});
      end
    end
    idle(5);
  endtask

  task automatic test_overlap();
    step();
    s_vld = 1'b1;
    s_adr = 32'h0000_0000;
    @(negedge clk);
    n_vec++;
    if (c_m_vld !== 2'b01) begin n_bad++; $display("FAIL ovl_vld0: got %b want 01", c_m_vld); end
    step();
    s_adr = 32'h8000_0000;
    @(negedge clk);
    n_vec++;
    if (c_m_vld !== 2'b01) begin n_bad++; $display("FAIL ovl_vld1: got %b want 01", c_m_vld); end
    step();
    s_vld = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({c_s_err, c_s_rdt} !== {1'b0, 32'h1111_1111}) begin n_bad++; $display("FAIL ovl_rsp0: got %h want 011111111", {c_s_err, c_s_rdt}); end
    step();
    @(negedge clk);
    n_vec++;
    if ({c_s_err, c_s_rdt} !== {1'b0, 32'h1111_1111}) begin n_bad++; $display("FAIL ovl_rsp1: got %h want 011111111", {c_s_err, c_s_rdt}); end
    step();
    @(negedge clk);
    n_vec++;
    if ({c_s_err, c_s_rdt} !== 33'h0) begin n_bad++; $display("FAIL ovl_after: got %h want 0", {c_s_err, c_s_rdt}); end
    idle(5);
  endtask

  task automatic test_reset_midflight();
    step();
    s_vld = 1'b1;
    s_adr = 32'h0000_0000;
    @(negedge clk);
    n_vec++;
    if (c_m_vld !== 2'b01) begin n_bad++; $display("FAIL rmf_req: got %b want 01", c_m_vld); end
    step();
    s_vld = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({a_s_err, a_s_rdt} !== 33'h0) begin n_bad++; $display("FAIL rmf_async_a: got %h want 0", {a_s_err, a_s_rdt}); end
    n_vec++;
    if ({c_s_err, c_s_rdt} !== 33'h0) begin n_bad++; $display("FAIL rmf_in_rst: got %h want 0", {c_s_err, c_s_rdt}); end
    step();
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({c_s_err, c_s_rdt} !== 33'h0) begin n_bad++; $display("FAIL rmf_stale: got %h want 0", {c_s_err, c_s_rdt}); end
    step();
    @(negedge clk);
    n_vec++;
    if ({c_s_err, c_s_rdt, b_s_err, b_s_rdt} !== 66'h0) begin n_bad++; $display("FAIL rmf_after: got %h want 0", {c_s_err, c_s_rdt, b_s_err, b_s_rdt}); end
    idle(3);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_broadcast();
    test_basic();
    test_backpressure();
    test_err_passthrough();
    test_unmapped();
    test_back_to_back();
    test_overlap();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
